tt_um_fiumad_alu_bist: RTL and testbench
========================================

TT_UM_FIUMAD_ALU_BIST -- requirements
Module: tt_um_fiumad_alu_bist

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port ena, input, 1 bit: powered indicator; ignored.
REQ-004 SHALL have port ui_in, input, 8 bits: result returned by the ALU under test.
REQ-005 SHALL have port uo_out, output, 8 bits: [7:4] operand A, [3:0] operand B driven to the ALU.
REQ-006 SHALL have port uio_in, input, 8 bits: [7] start; [6:0] unused.
REQ-007 SHALL have port uio_out, output, 8 bits: [2:0] op, [3] busy, [4] done, [5] fail, [6] issue strobe, [7] constant 0.
REQ-008 SHALL have port uio_oe, output, 8 bits: constant 8'b0111_1111.
REQ-009 SHALL have parameter LAT, default 2: cycles from vector issue to result sampling (ALU 1-cycle register plus 1 cycle board margin).

Function
REQ-010 SHALL act as the driving end of the 4-bit ALU: issue {A,B,op}, sample ui_in, compare to an internal golden model.
REQ-011 SHALL use golden ops: 0 A+B; 1 (A-B) mod 256; 2 A*B; 3 A/B (integer); 4 A&B; 5 A|B; all operands zero-extended to 8 bits, results 8-bit.
REQ-012 SHALL sweep op 0..5 (outer), A 0..15 (middle), B 0..15 (inner): 1536 vectors, ops 6/7 never issued.
REQ-013 SHALL skip vectors with op=3 and B=0 (no issue, no check, no cycles spent in ISSUE).
REQ-014 SHALL implement FSM states IDLE, ISSUE, WAIT, CHECK, DONE, FAIL.
REQ-015 IDLE -> ISSUE on rising edge of uio_in[7] (registered once, edge = current 1, previous 0); counters cleared to first vector.
REQ-016 ISSUE: drive vector, assert strobe for exactly 1 cycle -> WAIT.
REQ-017 WAIT: hold vector for LAT-1 cycles (down-counter) -> CHECK.
REQ-018 CHECK: compare ui_in to golden; mismatch -> FAIL; match and last vector -> DONE; match otherwise -> ISSUE with next vector.
REQ-019 Vector outputs (A, B, op) SHALL stay stable from ISSUE through CHECK of that vector.
REQ-020 Per-vector cost SHALL be LAT+1 cycles; full pass with LAT=2 is 1520 vectors x 3 = 4560 cycles from first ISSUE to DONE.
REQ-021 busy SHALL be 1 in ISSUE/WAIT/CHECK, else 0.
REQ-022 DONE: done=1, fail=0; FAIL: done=1, fail=1, failing {A,B,op} frozen on outputs.
REQ-023 Start edge SHALL be ignored while busy; a start edge in DONE or FAIL SHALL clear done/fail and restart the sweep from vector 0.
REQ-024 Start held high continuously SHALL trigger only once.
REQ-025 uio_in[6:0] and ena SHALL have no effect.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, uo_out=0, uio_out=0, all counters and start history 0.
REQ-027 Reset asserted mid-sweep SHALL abort; after release the block waits in IDLE for a new start edge.
REQ-028 After reset release, start already high SHALL not trigger (history must first see 0).

Verification
REQ-029 Reference-correct ALU model looped back, pulse start -> busy=1 next cycle, done=1 fail=0 after 4560 cycles, uio_out[7]=0 throughout.
REQ-030 ALU model with op 2 forced wrong for A=3,B=5 (returns 14) -> fail=1, uo_out=8'h35, uio_out[2:0]=2, halted.
REQ-031 Sweep of op 3 -> no strobe ever seen with B=0; A=15,B=2 checks 7.
REQ-032 Op 1 with A=0,B=1 -> expected 8'hFF accepted; returning 8'h0F -> FAIL.
REQ-033 Reset asserted at cycle 1000 of sweep -> all outputs 0 asynchronously; start held high across release -> stays IDLE until low then high.
REQ-034 Second start pulse mid-sweep -> ignored, completion time unchanged; start from FAIL -> fail clears, sweep restarts at A=0,B=0,op=0.

Source files
------------

// File: rtl/tt_um_fiumad_alu_bist.sv
// Built-in self-test driver for an external 4-bit ALU: sweeps every op/A/B
// vector, samples the ALU result LAT cycles after issue and compares it to a golden model.
module tt_um_fiumad_alu_bist #(
  parameter int LAT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_CHECK, S_DONE, S_FAIL
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  op, op_nxt;
  logic [3:0]  a, a_nxt, b, b_nxt;
  logic [7:0]  wait_cnt;
  logic [7:0]  gold;
  logic        start, start_q, armed, start_edge;
  logic        last_vec, match;
  logic        busy, done, fail, strobe;
  logic        unused;

  assign unused = &{ena, uio_in[6:0], 1'b0};

  // armed stays low after reset until start is seen low, so a start
  // already held across reset release cannot count as an edge.
  assign start      = uio_in[7];
  assign start_edge = start & ~start_q & armed;

  always_comb begin
    gold = '0;
    case (op)
      3'd0: gold = {4'b0, a} + {4'b0, b};
      3'd1: gold = {4'b0, a} - {4'b0, b};
      3'd2: gold = {4'b0, a} * {4'b0, b};
      3'd3: gold = (b == 4'd0) ? 8'd0 : {4'b0, a} / {4'b0, b};
      3'd4: gold = {4'b0, a} & {4'b0, b};
      3'd5: gold = {4'b0, a} | {4'b0, b};
      default: gold = '0;
    endcase
  end

  assign match = (ui_in == gold);

  // {op,a,b} as one counter gives the op/A/B nesting; divide-by-zero
  // vectors are stepped over so they never reach ISSUE.
  always_comb begin
    {op_nxt, a_nxt, b_nxt} = {op, a, b} + 11'd1;
    if (op_nxt == 3'd3 && b_nxt == 4'd0) b_nxt = 4'd1;
    last_vec = (op == 3'd5) && (a == 4'hF) && (b == 4'hF);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_FAIL: if (start_edge) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = (LAT > 1) ? S_WAIT : S_CHECK;
      S_WAIT:  if (wait_cnt <= 8'd1) state_nxt = S_CHECK;
      S_CHECK: begin
        if (!match)        state_nxt = S_FAIL;
        else if (last_vec) state_nxt = S_DONE;
        else               state_nxt = S_ISSUE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op       <= '0;
      a        <= '0;
      b        <= '0;
      wait_cnt <= '0;
      start_q  <= 1'b0;
      armed    <= 1'b0;
    end else begin
      start_q <= start;
      if (!start) armed <= 1'b1;
      case (state)
        S_IDLE, S_DONE, S_FAIL: if (start_edge) {op, a, b} <= '0;
        S_ISSUE: wait_cnt <= 8'(LAT - 1);
        S_WAIT:  wait_cnt <= wait_cnt - 8'd1;
        S_CHECK: if (match && !last_vec) {op, a, b} <= {op_nxt, a_nxt, b_nxt};
        default: ;
      endcase
    end
  end

  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    fail   = 1'b0;
    strobe = 1'b0;
    case (state)
      S_ISSUE: begin busy = 1'b1; strobe = 1'b1; end
      S_WAIT, S_CHECK: busy = 1'b1;
      S_DONE: done = 1'b1;
      S_FAIL: begin done = 1'b1; fail = 1'b1; end
      default: ;
    endcase
  end

  assign uo_out  = {a, b};
  assign uio_out = {1'b0, strobe, fail, done, busy, op};
  assign uio_oe  = 8'b0111_1111;

endmodule

// File: tb/tb_tt_um_fiumad_alu_bist.sv
// Loops a registered reference ALU (with optional injected fault) back into the
// BIST and scoreboards every issued vector against the expected sweep order.
module tb_tt_um_fiumad_alu_bist;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in = '0;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          c0;
  bit          mon_en = 1'b0;
  logic [10:0] exp_q[$];
  logic [10:0] last_issued = '0;
  logic [10:0] exp_v;

  bit          fault_en = 1'b0;
  logic [10:0] fault_vec = '0;
  logic [7:0]  fault_val = '0;
  logic [7:0]  alu_q = '0;

  tt_um_fiumad_alu_bist #(.LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] ref_alu(input logic [2:0] op, input logic [3:0] a, b);
    logic [7:0] x, y;
    x = {4'b0, a};
    y = {4'b0, b};
    case (op)
      3'd0: return x + y;
      3'd1: return x - y;
      3'd2: return x * y;
      3'd3: return (y == 0) ? 8'd0 : x / y;
      3'd4: return x & y;
      3'd5: return x | y;
      default: return 8'd0;
    endcase
  endfunction

  // ALU under test: one register stage, fed straight from the BIST outputs
  always @(posedge clk)
    alu_q <= (fault_en && {uio_out[2:0], uo_out} == fault_vec) ? fault_val
             : ref_alu(uio_out[2:0], uo_out[7:4], uo_out[3:0]);
  assign ui_in = alu_q;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    uio_in[7] = 1'b1;
    @(negedge clk);
    uio_in[7] = 1'b0;
  endtask

  // expected issue order, optionally cut at the vector where a fault stops the sweep
  task automatic build_q(input bit stop_en, input logic [10:0] stop_vec);
    exp_q.delete();
    for (int o = 0; o < 6; o++)
      for (int i = 0; i < 16; i++)
        for (int j = 0; j < 16; j++) begin
          if (o == 3 && j == 0) continue;
          exp_q.push_back({3'(o), 4'(i), 4'(j)});
          if (stop_en && {3'(o), 4'(i), 4'(j)} == stop_vec) return;
        end
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (!uio_out[4] && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("done_reached", {31'b0, uio_out[4]}, 1);
  endtask

  task automatic run_to_fail(input logic [10:0] vec, input logic [7:0] val);
    fault_en  = 1'b1;
    fault_vec = vec;
    fault_val = val;
    build_q(1'b1, vec);
    pulse_start();
    chk("restart_flags", {29'b0, uio_out[5:3]}, 3'b001);
    chk("restart_vec", {21'b0, uio_out[2:0], uo_out}, 0);
    wait_done(6000);
    chk("fail_flag", {31'b0, uio_out[5]}, 1);
    chk("fail_vec", {21'b0, uio_out[2:0], uo_out}, {21'b0, vec});
    chk("fail_q_empty", exp_q.size(), 0);
    tick(10);
    chk("fail_halt_out", {16'b0, uio_out, uo_out}, {16'b0, 2'b00, 3'b110, vec[10:8], vec[7:0]});
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("bit7", {31'b0, uio_out[7]}, 0);
      if (uio_out[6]) begin
        chk("issue_expected", {31'b0, exp_q.size() > 0}, 1);
        if (exp_q.size() > 0) begin
          exp_v = exp_q.pop_front();
          chk("issue_vec", {21'b0, uio_out[2:0], uo_out}, {21'b0, exp_v});
        end
        last_issued = {uio_out[2:0], uo_out};
      end else if (uio_out[3]) begin
        chk("vec_hold", {21'b0, uio_out[2:0], uo_out}, {21'b0, last_issued});
      end
    end
  end

  initial begin
    // reset state
    tick(3);
    chk("rst_uo", {24'b0, uo_out}, 0);
    chk("rst_uio", {24'b0, uio_out}, 0);
    chk("uio_oe", {24'b0, uio_oe}, 32'h7F);
    rst_n = 1'b1;
    tick(2);
    chk("idle_no_start", {24'b0, uio_out}, 0);

    // full clean sweep, with a stray start pulse mid-run
    build_q(1'b0, '0);
    mon_en = 1'b1;
    pulse_start();
    c0 = cyc;
    chk("busy_after_start", {31'b0, uio_out[3]}, 1);
    tick(600);
    pulse_start();
    wait_done(6000);
    chk("sweep_cycles", cyc - c0, 4560);
    chk("done_pass", {30'b0, uio_out[5:4]}, 2'b01);
    chk("sweep_q_empty", exp_q.size(), 0);
    tick(5);
    chk("done_sticky", {29'b0, uio_out[5:3]}, 3'b010);

    // injected faults, each restart coming from DONE or FAIL
    run_to_fail({3'd2, 4'd3, 4'd5}, 8'd14);
    run_to_fail({3'd1, 4'd0, 4'd1}, 8'h0F);
    run_to_fail({3'd3, 4'd15, 4'd2}, 8'd8);
    fault_en = 1'b0;

    // reset mid-sweep, start held high across release
    build_q(1'b0, '0);
    pulse_start();
    tick(1000);
    mon_en = 1'b0;
    uio_in[7] = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_uo", {24'b0, uo_out}, 0);
    chk("rst_async_uio", {24'b0, uio_out}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(5);
    chk("held_start_idle", {24'b0, uio_out}, 0);
    uio_in[7] = 1'b0;
    tick(2);
    build_q(1'b0, '0);
    mon_en = 1'b1;
    uio_in[7] = 1'b1;
    @(negedge clk);
    chk("restart_busy", {31'b0, uio_out[3]}, 1);
    wait_done(6000);
    chk("held_done", {30'b0, uio_out[5:4]}, 2'b01);
    tick(5);
    chk("held_no_retrigger", {29'b0, uio_out[5:3]}, 3'b010);
    chk("final_q_empty", exp_q.size(), 0);
    uio_in[7] = 1'b0;
    mon_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
